// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) checker: self-synchronising search/verify, then free-running
// reference while locked with windowed loss-of-lock detection and saturating BER counters.
module prbs_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int WIN_LEN    = 64,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam int WIN_W = $clog2(WIN_LEN + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t           r_state, w_state_nxt;
    logic [6:0]       r_sr, w_sr_nxt;
    logic [2:0]       r_fill, w_fill_nxt;
    logic [7:0]       r_match, w_match_nxt;
    logic [WIN_W-1:0] r_win_cnt, w_win_cnt_nxt;
    logic [WIN_W-1:0] r_win_err, w_win_err_nxt;
    logic [CNT_W-1:0] r_err_cnt, w_err_cnt_nxt;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
    logic             r_err_pulse, w_err_pulse_nxt;
    logic             w_p;
    logic             w_mis;

    assign w_p   = r_sr[6] ^ r_sr[5];
    assign w_mis = (din != w_p);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEARCH;
            r_sr        <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_fill      <= w_fill_nxt;
            r_match     <= w_match_nxt;
            r_win_cnt   <= w_win_cnt_nxt;
            r_win_err   <= w_win_err_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_err_pulse <= w_err_pulse_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_fill_nxt      = r_fill;
        w_match_nxt     = r_match;
        w_win_cnt_nxt   = r_win_cnt;
        w_win_err_nxt   = r_win_err;
        w_err_cnt_nxt   = r_err_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_err_pulse_nxt = 1'b0;
        if (din_valid) begin
            unique case (r_state)
                SEARCH: begin
                    w_sr_nxt = {r_sr[5:0], din};
                    if (r_fill == 3'd6) begin
                        w_state_nxt = VERIFY;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_fill_nxt = r_fill + 3'd1;
                    end
                end
                VERIFY: begin
                    w_sr_nxt = {r_sr[5:0], din};
                    // An all-zero reference predicts zeros forever; never count it as a match.
                    if (!w_mis && (r_sr != 7'd0)) begin
                        if (r_match == 8'(LOCK_CNT - 1)) begin
                            w_state_nxt   = LOCKED;
                            w_match_nxt   = '0;
                            w_win_cnt_nxt = '0;
                            w_win_err_nxt = '0;
                        end else begin
                            w_match_nxt = r_match + 8'd1;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_sr_nxt = {r_sr[5:0], w_p};
                    if (r_bit_cnt != '1) w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    if (w_mis) begin
                        w_err_pulse_nxt = 1'b1;
                        if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + 1'b1;
                    end
                    // Unlock wins over window rollover on the same bit.
                    if (w_mis && (r_win_err == WIN_W'(UNLOCK_ERR - 1))) begin
                        w_state_nxt = SEARCH;
                        w_fill_nxt  = '0;
                    end else if (r_win_cnt == WIN_W'(WIN_LEN - 1)) begin
                        w_win_cnt_nxt = '0;
                        w_win_err_nxt = '0;
                    end else begin
                        w_win_cnt_nxt = r_win_cnt + 1'b1;
                        w_win_err_nxt = r_win_err + {{(WIN_W-1){1'b0}}, w_mis};
                    end
                end
                default: w_state_nxt = SEARCH;
            endcase
        end
        if (clr_cnt) begin
            w_err_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
        end
    end

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign bit_cnt   = r_bit_cnt;
endmodule

// File: doc/prbs_checker.md
# prbs_checker

PRBS7 error checker for the CDR data path. It consumes the retimed bit stream produced by the data-recovery flip-flop stage, along with a bit strobe. It self-synchronises to the x^7+x^6+1 sequence, declares and drops lock, and counts bit errors. The results drive lock indication and BER measurement for the CDR test loop.

## Interface
- LOCK_CNT, 16: consecutive matching bits needed in VERIFY to declare lock (1..255).
- WIN_LEN, 64: length, in valid bits, of the error-monitoring window while locked (2..1023).
- UNLOCK_ERR, 4: errors within one window that force loss of lock (1..WIN_LEN).
- CNT_W, 16: width of err_cnt and bit_cnt.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  retimed data bit from the upstream flip-flop stage.
- din_valid  in  1  din is a new bit this cycle; when low, nothing changes except clr_cnt.
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt.
- locked  out  1  checker is in LOCKED state.
- err_pulse  out  1  one-cycle pulse per mismatching bit while locked.
- err_cnt  out  CNT_W  saturating count of errors while locked.
- bit_cnt  out  CNT_W  saturating count of bits checked while locked.

## Operation
- Reference register sr[6:0]. Predicted bit is p = sr[6] ^ sr[5]. Every shift is sr <= {sr[5:0], x}.
- State SEARCH (reset state):
  - Each valid bit shifts din into sr and increments fill_cnt.
  - When the 7th bit is loaded, go to VERIFY with match_cnt = 0.
- State VERIFY:
  - Each valid bit shifts din into sr (self-synchronising).
  - Match (din == p and sr != 0): match_cnt++.
  - Mismatch, or sr == 0: match_cnt = 0 and stay in VERIFY.
  - The all-zero guard means a constant-0 input never locks.
  - On the LOCK_CNT-th consecutive match, go to LOCKED and clear win_cnt and win_err.
- State LOCKED:
  - Each valid bit shifts p (not din) into sr, so the reference is free-running and a single line error produces exactly one mismatch.
  - Every valid bit: bit_cnt++ (saturating) and win_cnt++.
  - Mismatch (din != p): err_pulse = 1, err_cnt++ (saturating), win_err++.
  - When win_err reaches UNLOCK_ERR: go to SEARCH, fill_cnt = 0, locked falls. sr is not cleared.
  - When win_cnt reaches WIN_LEN without unlock: win_cnt = 0 and win_err = 0.
  - If the bit that completes the window is also the UNLOCK_ERR-th error, unlock takes priority.
- Counters:
  - err_cnt and bit_cnt saturate at 2^CNT_W-1 and hold.
  - They are not cleared by loss of lock; only rst or clr_cnt clears them.
  - clr_cnt beats a same-cycle increment: the result is 0, not 1.
- Reset mid-operation: in the next cycle state = SEARCH and every register and output = 0.

## Timing
- All outputs are registered. Reset value of locked, err_pulse, err_cnt and bit_cnt is 0.
- Lock latency: with an error-free stream, the (7+LOCK_CNT)-th valid bit is sampled at edge N; locked is high after edge N.
- err_pulse is high for exactly the one cycle following the edge that sampled the bad bit. err_cnt updates on the same edge.
- locked falls on the edge that samples the UNLOCK_ERR-th error in a window. That bit's err_pulse still fires and err_cnt still increments.
- Bits with din_valid low are ignored. Latency counts valid bits, not clocks.
- err_pulse is low whenever din_valid was low the previous cycle.

## Test plan
- Lock acquisition:
  - Stimulus: defaults, PRBS7 seeded 7'h7F, din_valid = 1 continuously.
  - Response: locked rises after the 23rd bit's edge; err_cnt = 0. After a further 1000 bits, bit_cnt = 1000.
- Single error while locked:
  - Stimulus: invert bit 200.
  - Response: exactly one err_pulse, err_cnt = 1, locked stays high, no further mismatches.
- Loss of lock and relock:
  - Stimulus: 4 inverted bits within one 64-bit window.
  - Response: locked drops on the 4th error's edge, err_cnt = 4, then relocks 23 clean bits later.
- Window reset:
  - Stimulus: 3 errors in window 1, 3 errors in window 2.
  - Response: locked never drops; err_cnt = 6.
- Gapped and degenerate inputs:
  - Stimulus: din_valid asserted every 3rd cycle.
  - Response: lock is declared after 23 valid bits.
  - Stimulus: constant din = 0 for 500 bits.
  - Response: locked stays 0.
- Counter edge cases:
  - Stimulus: CNT_W = 4 and UNLOCK_ERR = WIN_LEN = 64, with 20 errors.
  - Response: err_cnt saturates at 15.
  - Stimulus: clr_cnt in the same cycle as an error.
  - Response: err_cnt reads 0.
  - Stimulus: rst while locked.
  - Response: all outputs are 0 in the next cycle.
